// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - four-LED pattern sequencer: count, sweep, PWM breathe and off modes
module led_sequencer #(
    parameter int TICK_DIV = 12000000,
    parameter int PWM_BITS = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_next,
    input  logic       i_pause,
    output logic [3:0] o_led,
    output logic [1:0] o_mode,
    output logic       o_tick
);

    localparam int PSW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        M_COUNT   = 2'd0,
        M_SWEEP   = 2'd1,
        M_BREATHE = 2'd2,
        M_OFF     = 2'd3
    } mode_t;

    mode_t               mode;
    mode_t               mode_nxt;
    logic [PSW-1:0]      presc;
    logic                next_q;
    logic [3:0]          count;
    logic [1:0]          pos;
    logic                sweep_dn;
    logic [PWM_BITS-1:0] duty;
    logic                duty_dn;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [3:0]          led_nxt;
    logic                adv;
    logic                step;

    // A mode advance swallows any step that would land on the same edge.
    assign adv  = i_next & ~next_q;
    assign step = ~adv & ~i_pause & (presc == PS_LAST);

    always_comb begin
        mode_nxt = mode;
        led_nxt  = 4'b0000;
        if (adv) begin
            case (mode)
                M_COUNT:   mode_nxt = M_SWEEP;
                M_SWEEP:   mode_nxt = M_BREATHE;
                M_BREATHE: mode_nxt = M_OFF;
                default:   mode_nxt = M_COUNT;
            endcase
        end
        case (mode)
            M_COUNT:   led_nxt = count;
            M_SWEEP:   led_nxt = 4'b0001 << pos;
            M_BREATHE: led_nxt = {4{pwm_cnt < duty}};
            default:   led_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode     <= M_COUNT;
            presc    <= '0;
            next_q   <= 1'b1;
            count    <= 4'd0;
            pos      <= 2'd0;
            sweep_dn <= 1'b0;
            duty     <= '0;
            duty_dn  <= 1'b0;
            pwm_cnt  <= '0;
            o_led    <= 4'b0000;
            o_mode   <= 2'd0;
            o_tick   <= 1'b0;
        end else begin
            mode    <= mode_nxt;
            next_q  <= i_next;
            pwm_cnt <= pwm_cnt + 1'b1;
            o_led   <= led_nxt;
            o_mode  <= mode;
            o_tick  <= step;
            if (adv) begin
                presc    <= '0;
                count    <= 4'd0;
                pos      <= 2'd0;
                sweep_dn <= 1'b0;
                duty     <= '0;
                duty_dn  <= 1'b0;
            end else if (!i_pause) begin
                presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
                if (step) begin
                    case (mode)
                        M_COUNT: count <= count + 4'd1;
                        M_SWEEP: begin
                            if (!sweep_dn) begin
                                if (pos == 2'd3) begin
                                    pos      <= 2'd2;
                                    sweep_dn <= 1'b1;
                                end else begin
                                    pos <= pos + 2'd1;
                                end
                            end else if (pos == 2'd0) begin
                                pos      <= 2'd1;
                                sweep_dn <= 1'b0;
                            end else begin
                                pos <= pos - 2'd1;
                            end
                        end
                        // Ends are reached once and left on the following step.
                        M_BREATHE: begin
                            if (!duty_dn) begin
                                if (duty == DUTY_MAX) begin
                                    duty    <= DUTY_MAX - 1'b1;
                                    duty_dn <= 1'b1;
                                end else begin
                                    duty <= duty + 1'b1;
                                end
                            end else if (duty == '0) begin
                                duty    <= {{(PWM_BITS-1){1'b0}}, 1'b1};
                                duty_dn <= 1'b0;
                            end else begin
                                duty <= duty - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - randomized bench for led_sequencer against a step-index reference model
module tb_led_sequencer;

    localparam int TD = 4;
    localparam int PB = 3;
    localparam int DMAX = (1 << PB) - 1;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_next = 1'b0;
    logic       i_pause = 1'b0;
    logic [3:0] o_led;
    logic [1:0] o_mode;
    logic       o_tick;

    int errors = 0;
    int checks = 0;

    // reference state: mode, prescaler, steps taken since mode entry, pwm count
    int m_mode = 0;
    int m_presc = 0;
    int m_steps = 0;
    int m_pwm = 0;
    int m_prev = 1;
    int e_led = 0;
    int e_mode = 0;
    int e_tick = 0;

    led_sequencer #(.TICK_DIV(TD), .PWM_BITS(PB)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_next (i_next),
        .i_pause(i_pause),
        .o_led  (o_led),
        .o_mode (o_mode),
        .o_tick (o_tick)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int duty_of(input int k);
        int d;
        d = k % (2 * DMAX);
        return (d <= DMAX) ? d : 2 * DMAX - d;
    endfunction

    function automatic int pattern_led(input int md, input int k, input int pwm);
        int sweep_tab[6] = '{0, 1, 2, 3, 2, 1};
        case (md)
            0: return k % 16;
            1: return 1 << sweep_tab[k % 6];
            2: return (pwm < duty_of(k)) ? 15 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        if (i_reset) begin
            e_led = 0; e_mode = 0; e_tick = 0;
            m_mode = 0; m_presc = 0; m_steps = 0; m_pwm = 0; m_prev = 1;
        end else begin
            e_led  = pattern_led(m_mode, m_steps, m_pwm);
            e_mode = m_mode;
            e_tick = 0;
            if (i_next && !m_prev) begin
                m_mode  = (m_mode + 1) % 4;
                m_presc = 0;
                m_steps = 0;
            end else if (!i_pause) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    e_tick = 1;
                    if (m_mode != 3) m_steps++;
                end else begin
                    m_presc++;
                end
            end
            m_pwm  = (m_pwm + 1) % (DMAX + 1);
            m_prev = i_next;
        end
    endtask

    task automatic cyc(input logic r, input logic n, input logic p);
        i_reset = r; i_next = n; i_pause = p;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check("led", o_led, e_led);
        check("mode", o_mode, e_mode);
        check("tick", o_tick, e_tick);
    endtask

    task automatic goto_mode(input int md);
        for (int i = 0; i < 4 && m_mode != md; i++) begin
            cyc(0, 1, 0);
            cyc(0, 0, 0);
        end
    endtask

    initial begin
        int n;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        // count mode through a full wrap
        repeat (70) cyc(0, 0, 0);
        // freeze in count, then resume
        repeat (20) cyc(0, 0, 1);
        repeat (8) cyc(0, 0, 0);
        // sweep through a full bounce
        goto_mode(1);
        repeat (34) cyc(0, 0, 0);
        // breathe through both ends
        goto_mode(2);
        repeat (70) cyc(0, 0, 0);
        // edge coinciding with a step, held high ten cycles
        n = 0;
        while (m_presc != TD - 1 && n < 8) begin
            cyc(0, 0, 0);
            n++;
        end
        repeat (10) cyc(0, 1, 0);
        repeat (12) cyc(0, 0, 0);
        // reset in breathe with next held across release
        goto_mode(2);
        repeat (9) cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        repeat (12) cyc(0, 1, 0);
        cyc(0, 0, 0);
        // random mix
        repeat (3000) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 9) < 2));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
